// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus bridge.
// funct3 encodings, FSM state type, lane width, timeout counter sizing.
package lsu_pkg;

   localparam int BE_W = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP,
      DONE
   } state_t;

   // Counter must be able to hold the timeout value itself.
   function automatic int tmo_w(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / data replication,
// load lane extraction and extension, illegal/misaligned detection.
// Ports: req_* = live CPU request, ld_* = latched load + bus word,
//        be/wdata = store lanes, ld_data = extended load, bad = fault.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]      req_off,
   input  logic [2:0]      req_fn3,
   input  logic            req_we,
   input  logic [31:0]     req_wdata,
   input  logic [1:0]      ld_off,
   input  logic [2:0]      ld_fn3,
   input  logic [31:0]     ld_word,
   output logic [BE_W-1:0] be,
   output logic [31:0]     wdata,
   output logic [31:0]     ld_data,
   output logic            bad
);

   logic        legal;
   logic        mis;
   logic [7:0]  lb;
   logic [15:0] lh;

   always_comb begin
      be    = 4'b1111;
      wdata = req_wdata;
      if (req_we) begin
         case (req_fn3)
            F3_B: begin
               be    = 4'b0001 << req_off;
               wdata = {4{req_wdata[7:0]}};
            end
            F3_H: begin
               be    = 4'b0011 << {req_off[1], 1'b0};
               wdata = {2{req_wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      legal = 1'b0;
      case (req_fn3)
         F3_B, F3_H, F3_W: legal = 1'b1;
         F3_BU, F3_HU:     legal = !req_we;
         default:          legal = 1'b0;
      endcase
      mis = ((req_fn3[1:0] == 2'b01) && req_off[0]) ||
            ((req_fn3[1:0] == 2'b10) && (req_off != 2'b00));
      bad = !legal || mis;
   end

   always_comb begin
      lb      = ld_word[{ld_off, 3'b000} +: 8];
      lh      = ld_word[{ld_off[1], 4'b0000} +: 16];
      ld_data = ld_word;
      case (ld_fn3)
         F3_B:    ld_data = {{24{lb[7]}}, lb};
         F3_H:    ld_data = {{16{lh[15]}}, lh};
         F3_BU:   ld_data = {24'h0, lb};
         F3_HU:   ld_data = {16'h0, lh};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store unit replacing single-cycle data memory: runs a valid/ready
// bus transaction per access, stalls the CPU, reports faults.
// Ports: cpu_* = CPU memory stage side, bus_req_* / bus_rsp_* = data bus.
module lsu_bus_bridge
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_mem_read,
   input  logic              cpu_mem_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [2:0]        cpu_fn3,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              cpu_fault,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_req_we,
   output logic [ADDR_W-1:0] bus_req_addr,
   output logic [31:0]       bus_req_wdata,
   output logic [BE_W-1:0]   bus_req_be,
   input  logic              bus_rsp_valid,
   input  logic [31:0]       bus_rsp_rdata,
   input  logic              bus_rsp_err
);

   localparam int CW = tmo_w(TIMEOUT_CYC);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [1:0]      off_q;
   logic [2:0]      fn3_q;
   logic            err_q;
   logic [31:0]     rdata_q;

   logic            req;
   logic            go;
   logic            idle_flt;
   logic            tmo;
   logic [BE_W-1:0] a_be;
   logic [31:0]     a_wdata;
   logic [31:0]     a_ld;
   logic            a_bad;

   lsu_align u_align (
      .req_off   (cpu_addr[1:0]),
      .req_fn3   (cpu_fn3),
      .req_we    (cpu_mem_write),
      .req_wdata (cpu_wdata),
      .ld_off    (off_q),
      .ld_fn3    (fn3_q),
      .ld_word   (bus_rsp_rdata),
      .be        (a_be),
      .wdata     (a_wdata),
      .ld_data   (a_ld),
      .bad       (a_bad)
   );

   assign req      = cpu_mem_read || cpu_mem_write;
   assign go       = (state == IDLE) && req && !a_bad;
   assign idle_flt = (state == IDLE) && req && a_bad;
   // Fires in the last allowed cycle so DONE lands exactly TIMEOUT_CYC
   // cycles after REQ entry.
   assign tmo      = (cnt == TMO_LAST);

   // Gated by rst so a request held during reset cannot stall or fault.
   assign cpu_stall = rst && (go || state == REQ || state == RSP);
   assign cpu_fault = rst && (idle_flt || (state == DONE && err_q));
   assign cpu_rdata = idle_flt ? 32'h0 : rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         off_q         <= '0;
         fn3_q         <= '0;
         err_q         <= 1'b0;
         rdata_q       <= '0;
         bus_req_valid <= 1'b0;
         bus_req_we    <= 1'b0;
         bus_req_addr  <= '0;
         bus_req_wdata <= '0;
         bus_req_be    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  state         <= REQ;
                  cnt           <= '0;
                  err_q         <= 1'b0;
                  off_q         <= cpu_addr[1:0];
                  fn3_q         <= cpu_fn3;
                  bus_req_valid <= 1'b1;
                  bus_req_we    <= cpu_mem_write;
                  bus_req_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                  bus_req_wdata <= a_wdata;
                  bus_req_be    <= a_be;
               end else if (idle_flt) begin
                  rdata_q <= '0;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               if (tmo) begin
                  state         <= DONE;
                  bus_req_valid <= 1'b0;
                  err_q         <= 1'b1;
                  rdata_q       <= '0;
               end else if (bus_req_ready) begin
                  state         <= RSP;
                  bus_req_valid <= 1'b0;
               end
            end
            RSP: begin
               cnt <= cnt + 1'b1;
               if (tmo) begin
                  state   <= DONE;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else if (bus_rsp_valid) begin
                  state   <= DONE;
                  err_q   <= bus_rsp_err;
                  rdata_q <= bus_rsp_err ? 32'h0 : a_ld;
               end
            end
            DONE: begin
               state <= IDLE;
               err_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Scoreboard bench for lsu_bus_bridge: directed CPU accesses, a bus
// slave model checking requests, and a commit monitor checking results.
module tb_lsu_bus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_mem_read;
   logic        cpu_mem_write;
   logic [31:0] cpu_addr;
   logic [2:0]  cpu_fn3;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_fault;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_we;
   logic [31:0] bus_req_addr;
   logic [31:0] bus_req_wdata;
   logic [3:0]  bus_req_be;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_rdata;
   logic        bus_rsp_err;

   always #5 clk = ~clk;

   lsu_bus_bridge #(
      .TIMEOUT_CYC (8),
      .ADDR_W      (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_mem_read  (cpu_mem_read),
      .cpu_mem_write (cpu_mem_write),
      .cpu_addr      (cpu_addr),
      .cpu_fn3       (cpu_fn3),
      .cpu_wdata     (cpu_wdata),
      .cpu_rdata     (cpu_rdata),
      .cpu_stall     (cpu_stall),
      .cpu_fault     (cpu_fault),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_req_we    (bus_req_we),
      .bus_req_addr  (bus_req_addr),
      .bus_req_wdata (bus_req_wdata),
      .bus_req_be    (bus_req_be),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_rdata (bus_rsp_rdata),
      .bus_rsp_err   (bus_rsp_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   typedef struct {
      string       nm;
      logic [31:0] rdata;
      bit          chk_rd;
      logic        fault;
      int          stall;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   exp_t exp_q[$];
   bus_t bus_q[$];

   int          rdy_dly = 0;
   int          rsp_dly = 0;
   logic [31:0] rsp_data = 32'h0;
   logic        rsp_err = 1'b0;
   bit          blackhole = 1'b0;
   bit          pend = 1'b0;
   int          rwait = 0;

   // Bus slave: drives on the falling edge, checks each presented request.
   initial begin
      int   wcnt;
      bus_t b;
      wcnt          = 0;
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = 32'h0;
      bus_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         bus_req_ready = 1'b0;
         bus_rsp_valid = 1'b0;
         bus_rsp_rdata = 32'h0;
         bus_rsp_err   = 1'b0;
         if (!rst) begin
            pend = 1'b0;
            wcnt = 0;
         end else if (pend) begin
            if (rwait == 0) begin
               bus_rsp_valid = 1'b1;
               bus_rsp_rdata = rsp_data;
               bus_rsp_err   = rsp_err;
               pend          = 1'b0;
            end else begin
               rwait--;
            end
         end else if (bus_req_valid && !blackhole) begin
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL bus_unexpected addr=%h", bus_req_addr);
               bus_req_ready = 1'b1;
               pend          = 1'b1;
               rwait         = 0;
            end else begin
               b = bus_q[0];
               chk("bus_addr", bus_req_addr, b.addr);
               chk("bus_we", 32'(bus_req_we), 32'(b.we));
               chk("bus_be", 32'(bus_req_be), 32'(b.be));
               if (b.we) chk("bus_wdata", bus_req_wdata, b.wdata);
               if (wcnt == rdy_dly) begin
                  bus_req_ready = 1'b1;
                  void'(bus_q.pop_front());
                  pend  = 1'b1;
                  rwait = rsp_dly;
                  wcnt  = 0;
               end else begin
                  wcnt++;
               end
            end
         end
      end
   end

   // Commit monitor: a request with cpu_stall low is the commit cycle.
   initial begin
      int   sc;
      exp_t e;
      sc = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            sc = 0;
         end else if (cpu_mem_read || cpu_mem_write) begin
            if (cpu_stall) begin
               sc++;
            end else begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL commit_unexpected addr=%h", cpu_addr);
               end else begin
                  e = exp_q.pop_front();
                  chk({e.nm, "_fault"}, 32'(cpu_fault), 32'(e.fault));
                  chk({e.nm, "_stall"}, 32'(sc), 32'(e.stall));
                  chk({e.nm, "_valid"}, 32'(bus_req_valid), 32'h0);
                  if (e.chk_rd) chk({e.nm, "_rdata"}, cpu_rdata, e.rdata);
               end
               sc = 0;
            end
         end
      end
   end

   task automatic issue(input string nm, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input bit push,
                        input logic [31:0] ea, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] erd,
                        input bit crd, input logic efl, input int est);
      exp_t e;
      bus_t b;
      int   n;
      @(posedge clk);
      #1;
      cpu_mem_read  = rd;
      cpu_mem_write = wr;
      cpu_addr      = a;
      cpu_fn3       = f3;
      cpu_wdata     = wd;
      e.nm     = nm;
      e.rdata  = erd;
      e.chk_rd = crd;
      e.fault  = efl;
      e.stall  = est;
      exp_q.push_back(e);
      if (push) begin
         b.addr  = ea;
         b.we    = wr;
         b.be    = ebe;
         b.wdata = ewd;
         bus_q.push_back(b);
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cpu_stall && n < 100);
      if (cpu_stall) begin
         checks++;
         errors++;
         $display("FAIL %s_hang got=stall exp=commit", nm);
      end
      @(posedge clk);
      #1;
      cpu_mem_read  = 1'b0;
      cpu_mem_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b0;
      cpu_mem_read  = 1'b0;
      cpu_mem_write = 1'b0;
      cpu_addr      = 32'h0;
      cpu_fn3       = 3'b000;
      cpu_wdata     = 32'h0;
      #12;
      chk("rst_stall", 32'(cpu_stall), 32'h0);
      chk("rst_fault", 32'(cpu_fault), 32'h0);
      chk("rst_valid", 32'(bus_req_valid), 32'h0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_be", 32'(bus_req_be), 32'h0);
      chk("rst_addr", bus_req_addr, 32'h0);
      // Requests during reset must neither stall nor fault.
      cpu_mem_read = 1'b1;
      cpu_fn3      = 3'b010;
      #1;
      chk("rst_req_stall", 32'(cpu_stall), 32'h0);
      cpu_fn3 = 3'b011;
      #1;
      chk("rst_req_fault", 32'(cpu_fault), 32'h0);
      cpu_mem_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // LB 0x103: lane 3 of 0x80FF1234 is 0x80 -> sign extended.
      rdy_dly = 0; rsp_dly = 1; rsp_data = 32'h80FF_1234;
      issue("lb", 1, 0, 32'h103, 3'b000, 32'h0, 1, 32'h100, 4'b1111,
            32'h0, 32'hFFFF_FF80, 1, 0, 4);
      // SH 0x12: upper half lanes, data replicated, ready after 3 waits.
      rdy_dly = 3; rsp_dly = 0;
      issue("sh", 0, 1, 32'h12, 3'b001, 32'h1234_ABCD, 1, 32'h10, 4'b1100,
            32'hABCD_ABCD, 32'h0, 0, 0, 6);
      rdy_dly = 0;
      issue("sb", 0, 1, 32'h21, 3'b000, 32'h0000_00A5, 1, 32'h20, 4'b0010,
            32'hA5A5_A5A5, 32'h0, 0, 0, 3);
      // Read and write both high behaves as a store.
      issue("sw_rw", 1, 1, 32'h40, 3'b010, 32'hDEAD_BEEF, 1, 32'h40,
            4'b1111, 32'hDEAD_BEEF, 32'h0, 0, 0, 3);
      // Faults raised in IDLE: no bus access, no stall, rdata zero.
      issue("lw_mis", 1, 0, 32'h6, 3'b010, 32'h0, 0, 32'h0, 4'h0,
            32'h0, 32'h0, 1, 1, 0);
      issue("lh_mis", 1, 0, 32'h5, 3'b001, 32'h0, 0, 32'h0, 4'h0,
            32'h0, 32'h0, 1, 1, 0);
      issue("ld_f3", 1, 0, 32'h0, 3'b011, 32'h0, 0, 32'h0, 4'h0,
            32'h0, 32'h0, 1, 1, 0);
      issue("st_f3", 0, 1, 32'h0, 3'b100, 32'h0, 0, 32'h0, 4'h0,
            32'h0, 32'h0, 1, 1, 0);
      issue("sh_mis", 0, 1, 32'h3, 3'b001, 32'h0, 0, 32'h0, 4'h0,
            32'h0, 32'h0, 1, 1, 0);

      // Silent bus: DONE with fault 8 cycles after REQ entry.
      blackhole = 1'b1;
      issue("lw_tmo", 1, 0, 32'h50, 3'b010, 32'h0, 0, 32'h0, 4'h0,
            32'h0, 32'h0, 1, 1, 9);
      blackhole = 1'b0;
      // Stale response in IDLE must be ignored.
      rsp_data = 32'h1111_1111;
      @(posedge clk);
      #1;
      pend  = 1'b1;
      rwait = 0;
      @(negedge clk);
      #1;
      chk("late_stall", 32'(cpu_stall), 32'h0);
      chk("late_fault", 32'(cpu_fault), 32'h0);
      @(negedge clk);
      #1;
      chk("late_rdata", cpu_rdata, 32'h0);
      chk("late_valid", 32'(bus_req_valid), 32'h0);

      rsp_err = 1'b1; rsp_data = 32'h1234_5678;
      issue("lw_err", 1, 0, 32'h60, 3'b010, 32'h0, 1, 32'h60, 4'b1111,
            32'h0, 32'h0, 1, 1, 3);
      rsp_err = 1'b0; rsp_data = 32'h8001_0000;
      issue("lhu", 1, 0, 32'h2, 3'b101, 32'h0, 1, 32'h0, 4'b1111,
            32'h0, 32'h0000_8001, 1, 0, 3);
      issue("lh", 1, 0, 32'h2, 3'b001, 32'h0, 1, 32'h0, 4'b1111,
            32'h0, 32'hFFFF_8001, 1, 0, 3);
      rsp_data = 32'h0000_C300;
      issue("lbu", 1, 0, 32'h1, 3'b100, 32'h0, 1, 32'h0, 4'b1111,
            32'h0, 32'h0000_00C3, 1, 0, 3);
      rsp_data = 32'h007F_0000;
      issue("lb_pos", 1, 0, 32'h2, 3'b000, 32'h0, 1, 32'h0, 4'b1111,
            32'h0, 32'h0000_007F, 1, 0, 3);

      // Reset while waiting in RSP.
      rsp_dly = 6; rsp_data = 32'h0000_0055;
      begin
         bus_t b;
         b.addr = 32'h8; b.we = 1'b0; b.be = 4'b1111; b.wdata = 32'h0;
         bus_q.push_back(b);
      end
      @(posedge clk);
      #1;
      cpu_mem_read = 1'b1;
      cpu_addr     = 32'h8;
      cpu_fn3      = 3'b010;
      repeat (3) @(negedge clk);
      #1;
      chk("pre_rst_stall", 32'(cpu_stall), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_stall", 32'(cpu_stall), 32'h0);
      chk("mid_rst_fault", 32'(cpu_fault), 32'h0);
      chk("mid_rst_valid", 32'(bus_req_valid), 32'h0);
      chk("mid_rst_rdata", cpu_rdata, 32'h0);
      cpu_mem_read = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      rsp_dly = 0;
      rsp_data = 32'hCAFE_F00D;
      issue("lw_post", 1, 0, 32'h0, 3'b010, 32'h0, 1, 32'h0, 4'b1111,
            32'h0, 32'hCAFE_F00D, 1, 0, 3);

      repeat (2) @(negedge clk);
      chk("exp_q_left", 32'(exp_q.size()), 32'h0);
      chk("bus_q_left", 32'(bus_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit sitting directly downstream of the RV32I datapath's ALU/memory stage, in place of the single-cycle data memory.
- Takes the CPU's memory request (ALU address, funct3, rs2 data, MemRead/MemWrite) and runs a multi-cycle valid/ready transaction on a word-wide data bus with byte enables.
- Handles alignment, byte/halfword lane placement and load sign/zero extension.
- Stalls the CPU (gates PC update and RegWrite) until the access completes, and reports faults.

Parameters:
- TIMEOUT_CYC, 255, max cycles spent in REQ+RSP before abort with fault; 1..65535.
- ADDR_W, 32, CPU/bus address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- cpu_mem_read  in  1  load request (CU MemRead)
- cpu_mem_write  in  1  store request (CU MemWrite)
- cpu_addr  in  ADDR_W  byte address from ALU
- cpu_fn3  in  3  instruction funct3 (size/sign)
- cpu_wdata  in  32  store data (rs2)
- cpu_rdata  out  32  extended load data; valid in the DONE cycle
- cpu_stall  out  1  hold PC and suppress RegWrite
- cpu_fault  out  1  access fault pulse (misaligned/illegal/bus error/timeout)
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_we  out  1  1 = write
- bus_req_addr  out  ADDR_W  word-aligned address, {cpu_addr[ADDR_W-1:2],2'b00}
- bus_req_wdata  out  32  lane-replicated store data
- bus_req_be  out  4  byte enables (all 1 for reads)
- bus_rsp_valid  in  1  response valid; one per accepted request, reads and writes
- bus_rsp_rdata  in  32  read word
- bus_rsp_err  in  1  bus error, qualified by bus_rsp_valid

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE.
- Reset (rst=0, async): state IDLE, timeout counter 0, all registered outputs 0. cpu_stall and cpu_fault are forced 0 while rst=0.
- Request decode:
  - Request = cpu_mem_read | cpu_mem_write. If both are high, treat as a write.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Anything else is illegal.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- IDLE, legal and aligned request:
  - cpu_stall=1 combinationally in the same cycle.
  - Latch addr, fn3, we, be, wdata; go to REQ.
- IDLE, illegal or misaligned request:
  - No bus access; cpu_fault=1 and cpu_stall=0 in that cycle; cpu_rdata=0; stay in IDLE.
  - The store is dropped.
- REQ:
  - bus_req_valid=1; address, data, be and we held stable until bus_req_ready.
  - On valid&ready go to RSP.
- RSP:
  - Wait for bus_rsp_valid.
  - Register extracted/extended data into cpu_rdata; record fault = bus_rsp_err.
  - Go to DONE.
  - A response in the same cycle as acceptance is not legal bus behaviour; the response is sampled only in RSP.
- Stall: cpu_stall=1 throughout REQ and RSP.
- DONE:
  - cpu_stall=0; cpu_rdata valid; cpu_fault=1 if an error was recorded (cpu_rdata=0 on error).
  - The CPU commits in this cycle. Next state is IDLE.
  - A back-to-back request is then seen in IDLE, so there is at least one idle cycle between bus transactions (intentional).
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/RSP.
  - When it reaches TIMEOUT_CYC, go to DONE with fault=1 and drop bus_req_valid.
  - A stale bus response arriving later in IDLE or DONE is ignored.
- Store lanes (o = addr[1:0]):
  - SB: be = 4'b0001<<o, wdata = {4{b[7:0]}}.
  - SH: be = 4'b0011<<(2*addr[1]), wdata = {2{h[15:0]}}.
  - SW: be = 4'b1111.
- Load extract: byte lane = rdata[8*o +: 8]; half = rdata[16*addr[1] +: 16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Reset mid-transaction: immediate return to IDLE; the bus slave shares the same reset, so no response is owed.
- cpu_rdata holds its value outside DONE; it is not cleared except by reset or a fault.

Decomposition:
- lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum (IDLE/REQ/RSP/DONE)
  - BE_W=4
  - TIMEOUT counter width derivation
- Sub-module lsu_align (combinational):
  - store be/wdata generation
  - load extraction/extension
  - misaligned/illegal detection
- The FSM, counter and registers stay in lsu_bus_bridge.

Test Plan:
- LB at 0x0000_0103, bus returns 0x80FF_1234 after 2 wait cycles → cpu_stall high 4 cycles, DONE cpu_rdata=0xFFFF_FF80, fault 0.
- SH at 0x0000_0012, rs2=0x1234_ABCD, ready delayed 3 cycles → bus_req_addr=0x10, be=1100, wdata=0xABCD_ABCD, held stable until ready.
- LW at 0x0000_0006 → no bus_req_valid, cpu_fault=1, cpu_stall=0 in the same cycle; funct3=011 load also faults.
- TIMEOUT_CYC=8, bus never responds → fault in DONE exactly 8 cycles after REQ entry; a late bus_rsp_valid in IDLE is ignored.
- Read with bus_rsp_err=1 → cpu_rdata=0, cpu_fault=1 for one cycle; next LHU at 0x2, rdata 0x8001_0000 → 0x0000_8001.
- rst pulled low during RSP → outputs 0 asynchronously; after release, an LW at 0x0 completes normally.
